// File: rtl/melody_seq_ctl.sv
// Song sequencer: walks a synchronous song ROM and feeds the tone generator a
// half-period divider plus a mute qualifier, with play/pause/stop and looping.
module melody_seq_ctl #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int ADDR_W      = 6
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [25:0]       rom_data,
  output logic [21:0]       note_div,
  output logic              mute,
  output logic              playing,
  output logic              song_end
);

  localparam int CNT_W = $clog2(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  // One extra bit so a zero-length gap (threshold == BEAT_CYCLES) never wraps.
  localparam logic [CNT_W:0]   GAP_START = (CNT_W + 1)'(BEAT_CYCLES - GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_PAUSE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [21:0]       note_div_q, note_div_d;
  logic              mute_q, mute_d;
  logic              song_end_q, song_end_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]        beats_left_q, beats_left_d;

  logic [3:0]        rom_dur;
  logic [21:0]       rom_div;

  assign rom_dur = rom_data[25:22];
  assign rom_div = rom_data[21:0];

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      note_div_q   <= '0;
      mute_q       <= 1'b1;
      song_end_q   <= 1'b0;
      beat_cnt_q   <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      note_div_q   <= note_div_d;
      mute_q       <= mute_d;
      song_end_q   <= song_end_d;
      beat_cnt_q   <= beat_cnt_d;
      beats_left_q <= beats_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    note_div_d   = note_div_q;
    song_end_d   = 1'b0;
    beat_cnt_d   = beat_cnt_q;
    beats_left_d = beats_left_q;
    mute_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        note_div_d = '0;
        if (start) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_dur != 4'd0) begin
          note_div_d   = rom_div;
          beats_left_d = rom_dur;
          beat_cnt_d   = '0;
          rom_addr_d   = rom_addr_q + 1'b1;
          state_d      = S_PLAY;
        end else begin
          song_end_d = 1'b1;
          if (loop_en && (rom_addr_q != '0)) begin
            rom_addr_d = '0;
            state_d    = S_FETCH;
          end else begin
            note_div_d = '0;
            state_d    = S_IDLE;
          end
        end
      end
      S_PLAY: begin
        // A pause pulse freezes the counters on the cycle it arrives.
        if (pause) begin
          state_d = S_PAUSE;
        end else if (beat_cnt_q == BEAT_LAST) begin
          beat_cnt_d   = '0;
          beats_left_d = beats_left_q - 4'd1;
          if (beats_left_q == 4'd1) state_d = S_FETCH;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (start || pause) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      note_div_d = '0;
      song_end_d = 1'b0;
    end

    // Mute is computed from next-state values so it lines up with its cycle.
    if (state_d == S_PLAY) begin
      mute_d = (note_div_d == '0) ||
               ((beats_left_d == 4'd1) && ({1'b0, beat_cnt_d} >= GAP_START));
    end
  end

  assign rom_addr = rom_addr_q;
  assign note_div = note_div_q;
  assign mute     = mute_q;
  assign song_end = song_end_q;
  assign playing  = (state_q != S_IDLE);

endmodule

// File: tb/tb_melody_seq_ctl.sv
// Bench for melody_seq_ctl: directed scenarios plus randomized songs, checked
// against a note-by-note timeline built from the song table.
module tb_melody_seq_ctl;

  localparam int BEAT   = 4;
  localparam int GAP    = 1;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_100mhz = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [25:0]       rom_data;
  logic [21:0]       note_div;
  logic              mute;
  logic              playing;
  logic              song_end;

  logic [25:0]       rom [DEPTH];

  int checks = 0;
  int errors = 0;
  string scen = "";

  typedef struct packed {
    logic [21:0]       div;
    logic              mute;
    logic              play;
    logic              send;
    logic [ADDR_W-1:0] addr;
    logic              inplay;
  } exp_t;

  exp_t exp_q[$];

  melody_seq_ctl #(
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAP),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_div  (note_div),
    .mute      (mute),
    .playing   (playing),
    .song_end  (song_end)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) rom_data <= rom[rom_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [21:0] d, input logic m, input logic p,
                              input logic s, input int a, input logic ip);
    exp_t e;
    e.div    = d;
    e.mute   = m;
    e.play   = p;
    e.send   = s;
    e.addr   = ADDR_W'(a);
    e.inplay = ip;
    return e;
  endfunction

  // Timeline of a song from the cycle after the start pulse: two muted cycles
  // before each entry, dur*BEAT note cycles whose last GAP are muted.
  task automatic build(input bit lp, input int n);
    int          addr;
    int          len;
    logic [21:0] cur;
    logic [21:0] dv;
    logic [3:0]  du;
    logic        pend;
    exp_q.delete();
    addr = 0;
    cur  = '0;
    pend = 1'b0;
    while (exp_q.size() < n) begin
      exp_q.push_back(mk(cur, 1'b1, 1'b1, pend, addr, 1'b0));
      pend = 1'b0;
      exp_q.push_back(mk(cur, 1'b1, 1'b1, 1'b0, addr, 1'b0));
      du = rom[addr][25:22];
      dv = rom[addr][21:0];
      if (du != 4'd0) begin
        cur  = dv;
        len  = int'(du) * BEAT;
        addr = (addr + 1) % DEPTH;
        for (int k = 0; k < len; k++)
          exp_q.push_back(mk(dv, (dv == '0) || (k >= len - GAP), 1'b1, 1'b0, addr, 1'b1));
      end else begin
        pend = 1'b1;
        if (lp && addr != 0) begin
          addr = 0;
        end else begin
          exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b1, addr, 1'b0));
          while (exp_q.size() < n) exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, addr, 1'b0));
        end
      end
    end
  endtask

  // Pausing at play cycle i adds p muted cycles, after which cycle i recurs.
  task automatic inject_pause(input int i, input int p);
    exp_t e;
    e = exp_q[i];
    exp_q.insert(i + 1, e);
    for (int k = 0; k < p; k++)
      exp_q.insert(i + 1, mk(e.div, 1'b1, 1'b1, 1'b0, int'(e.addr), 1'b0));
  endtask

  task automatic chk_exp(input int i);
    exp_t e;
    e = exp_q[i];
    chk($sformatf("%s div@%0d", scen, i), 32'(note_div), 32'(e.div));
    chk($sformatf("%s mute@%0d", scen, i), 32'(mute), 32'(e.mute));
    chk($sformatf("%s playing@%0d", scen, i), 32'(playing), 32'(e.play));
    chk($sformatf("%s song_end@%0d", scen, i), 32'(song_end), 32'(e.send));
    chk($sformatf("%s rom_addr@%0d", scen, i), 32'(rom_addr), 32'(e.addr));
  endtask

  task automatic chk_idle(input string tag);
    chk({scen, " ", tag, " rom_addr"}, 32'(rom_addr), 32'd0);
    chk({scen, " ", tag, " div"}, 32'(note_div), 32'd0);
    chk({scen, " ", tag, " mute"}, 32'(mute), 32'd1);
    chk({scen, " ", tag, " playing"}, 32'(playing), 32'd0);
    chk({scen, " ", tag, " song_end"}, 32'(song_end), 32'd0);
  endtask

  task automatic run(input int n, input int pause_i, input int resume_i,
                     input int start_i, input int abort_i, input bit abort_rst);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_exp(i);
      if (i == abort_i) begin
        if (abort_rst) begin
          rst = 1'b1;
        end else begin
          stop  = 1'b1;
          start = 1'b1;
          pause = 1'b1;
        end
        tick();
        rst = 1'b0; stop = 1'b0; start = 1'b0; pause = 1'b0;
        chk_idle("abort");
        tick();
        chk_idle("abort+1");
        return;
      end
      if (i == pause_i) pause = 1'b1;
      if (i == resume_i || i == start_i) start = 1'b1;
      tick();
      pause = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic load_plan();
    for (int j = 0; j < DEPTH; j++) rom[j] = 26'd0;
    rom[0] = {4'd2, 22'd191112};
    rom[1] = {4'd1, 22'd0};
    rom[2] = {4'd1, 22'd170264};
    rom[3] = {4'd0, 22'h2AAAAA};
  endtask

  initial begin
    int idxs[$];
    int pi;
    int pl;
    int k;
    bit lp;
    load_plan();

    scen = "reset";
    tick(); tick();
    chk_idle("rst");
    rst = 1'b0;
    tick();
    chk_idle("post");

    scen = "s1";
    loop_en = 1'b0;
    build(1'b0, 27);
    run(27, -1, -1, 5, -1, 1'b0);

    scen = "s2";
    loop_en = 1'b1;
    build(1'b1, 60);
    run(60, -1, -1, -1, 59, 1'b0);

    scen = "s3";
    loop_en = 1'b0;
    build(1'b0, 27);
    inject_pause(3, 10);
    run(exp_q.size(), 3, 13, -1, -1, 1'b0);

    scen = "s4";
    build(1'b0, 27);
    run(27, -1, -1, -1, 19, 1'b0);

    scen = "s5";
    loop_en = 1'b1;
    rom[0] = {4'd0, 22'h155555};
    build(1'b1, 8);
    run(8, -1, -1, -1, -1, 1'b0);

    scen = "s6";
    loop_en = 1'b0;
    load_plan();
    build(1'b0, 27);
    run(27, -1, -1, 4, 7, 1'b1);

    for (int r = 0; r < 4; r++) begin
      scen = $sformatf("rnd%0d", r);
      k = $urandom_range(1, 5);
      lp = 1'($urandom_range(0, 1));
      for (int j = 0; j < DEPTH; j++)
        rom[j] = {4'($urandom_range(1, 3)),
                  ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom_range(1, 4194303))};
      rom[k] = {4'd0, 22'($urandom)};
      loop_en = lp;
      build(lp, 120);
      idxs.delete();
      foreach (exp_q[j]) if (exp_q[j].inplay) idxs.push_back(j);
      pi = idxs[$urandom_range(0, idxs.size() - 1)];
      pl = $urandom_range(1, 6);
      inject_pause(pi, pl);
      run(exp_q.size(), pi, pi + pl, -1, exp_q.size() - 1, 1'b0);
    end

    scen = "wrap";
    loop_en = 1'b0;
    for (int j = 0; j < DEPTH; j++)
      rom[j] = {4'd1, ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom_range(1, 4194303))};
    build(1'b0, 80);
    run(80, -1, -1, -1, 79, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_seq_ctl.md
Name: melody_seq_ctl

Overview:
- Sequences the tone generator: walks a song table in a synchronous ROM and drives the generator's 22-bit half-period divider (note_div) plus a mute qualifier.
- Each ROM entry holds one note (divider and duration in beats).
- Provides play, pause and stop control, optional looping, and articulation gaps between notes.
- Sits between the board control logic (debounced, one-pulse buttons) and the tone generator / audio serializer.

Parameters:
- BEAT_CYCLES, 25_000_000, clk_100mhz cycles per beat (0.25 s); must be ≥ 2.
- GAP_CYCLES, 2_500_000, muted cycles at the end of each note; must be < BEAT_CYCLES.
- ADDR_W, 6, song ROM address width (2^ADDR_W entries).

Ports:
- clk_100mhz  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high; sampled on the rising edge of clk_100mhz.
- start  in  1  one-cycle pulse; begin from entry 0 when IDLE, resume when PAUSE.
- pause  in  1  one-cycle pulse; toggles PLAY↔PAUSE.
- stop  in  1  one-cycle pulse; abort to IDLE from any state.
- loop_en  in  1  level; restart at entry 0 when the end marker is reached.
- rom_addr  out  ADDR_W  song ROM address (registered).
- rom_data  in  26  {dur[25:22], div[21:0]}; valid one cycle after rom_addr changes.
- note_div  out  22  divider to the tone generator (registered).
- mute  out  1  1 = tone generator output must be silenced.
- playing  out  1  1 in FETCH, LOAD, PLAY and PAUSE.
- song_end  out  1  one-cycle pulse when the end marker is consumed.

Behaviour:
- Reset values (rst=1 at an edge): state IDLE, rom_addr=0, note_div=0, mute=1, playing=0, song_end=0, beat_cnt=0, beats_left=0.
- Entry encoding:
  - dur=0: end marker.
  - div=0 with dur≠0: rest (mute=1 for the whole note).
- Control priority when pulses coincide: stop > start > pause.
- States:
  - IDLE: mute=1, note_div=0. On start: rom_addr←0, go to FETCH.
  - FETCH: one cycle; waits out the ROM latency. mute=1.
  - LOAD: latch rom_data.
    - dur≠0: note_div←div, beats_left←dur, beat_cnt←0, rom_addr←rom_addr+1 (wraps modulo 2^ADDR_W), go to PLAY.
    - dur=0: song_end=1 for one cycle. If loop_en=1 and rom_addr≠0: rom_addr←0, go to FETCH. Otherwise (no loop, or marker at entry 0 meaning an empty song): go to IDLE with note_div←0.
  - PLAY: beat_cnt increments each cycle.
    - When beat_cnt reaches BEAT_CYCLES-1, it resets to 0 and beats_left decrements.
    - When beat_cnt=BEAT_CYCLES-1 and beats_left=1, go to FETCH.
    - Note length in PLAY is exactly dur×BEAT_CYCLES cycles.
    - Between notes there are exactly 2 cycles (FETCH, LOAD), both with mute=1.
  - PAUSE: beat_cnt, beats_left, rom_addr and note_div are all frozen; mute=1. On pause or start, return to PLAY and continue from the frozen count.
  - pause pulses in IDLE, FETCH or LOAD are ignored.
- mute in PLAY is 1 iff either:
  - note_div=0, or
  - beats_left=1 and beat_cnt ≥ BEAT_CYCLES-GAP_CYCLES.
  - mute is registered and aligned with the cycle whose state it qualifies.
- stop in any state:
  - Next cycle: IDLE, rom_addr=0, note_div=0, mute=1.
  - song_end is not pulsed.
- Reset mid-note overrides everything; outputs return to their reset values the next cycle.
- start while in PLAY, FETCH or LOAD is ignored; it does not restart the song.
- loop_en is sampled only in LOAD.
- Wrap-around: an entry at address 2^ADDR_W-1 with dur≠0 advances rom_addr to 0 without any song_end pulse.
- Counter widths: beat_cnt is $clog2(BEAT_CYCLES) bits; beats_left is 4 bits.

Test Plan:
All scenarios use BEAT_CYCLES=4, GAP_CYCLES=1, ADDR_W=3. ROM contents:
- entry 0: {2, 191112}
- entry 1: {1, 0}
- entry 2: {1, 170264}
- entry 3: {0, x}

Scenarios:
1. Reset, then start pulse with loop_en=0 → rom_addr 0 in FETCH, then LOAD. Entry 0 plays: note_div=191112 for 8 PLAY cycles, mute=0 for 7 and 1 on the 8th. 2 muted FETCH/LOAD cycles follow. Entry 1 (rest): 4 cycles with mute=1. Entry 2: note_div=170264 with mute 0,0,0,1. Marker: song_end pulses once, then IDLE, note_div=0, playing=0.
2. Same ROM with loop_en=1 → after the marker, rom_addr returns to 0 and entry 0 replays (note_div=191112). song_end pulses once per pass; playing stays 1.
3. pause pulse at beat_cnt=1 of entry 0's first beat → mute=1 and counters frozen for 10 cycles. The following start pulse resumes: 7 further PLAY cycles of entry 0 remain.
4. stop asserted together with start and pause during entry 2 → next cycle IDLE, rom_addr=0, note_div=0, mute=1, no song_end pulse.
5. ROM entry 0 = {0, x} with loop_en=1 → a single song_end pulse, then IDLE with no further fetches.
6. rst=1 for one cycle during PLAY → all outputs return to reset values the next cycle. start pulses in PLAY have no effect on rom_addr.
